// File: rtl/tinyalu_param_if.sv
// Start/done handshake bus between a TinyALU master (BFM) and the parameterised ALU.
// Signal names match the existing opcode/handshake bus so current BFMs bind unchanged.
interface tinyalu_param_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [2:0]         op;
  logic               start;
  logic               done;
  logic [2*WIDTH-1:0] result;
  logic               err;
  logic               busy;

  modport master (output A, B, op, start, input  done, result, err, busy);
  modport slave  (input  A, B, op, start, output done, result, err, busy);
endinterface

// File: rtl/tinyalu_param.sv
// Parameterised TinyALU: captures operands on start, single-cycle add/and/xor/sub,
// MUL_LAT-cycle multiply, illegal-opcode flag, one done pulse per accepted request.
module tinyalu_param #(
  parameter int WIDTH   = 8,
  parameter int MUL_LAT = 3   // 1..16
) (
  input  logic           clk,
  input  logic           reset_n,
  tinyalu_param_if.slave bus
);
  localparam int RW    = 2 * WIDTH;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_AND = 3'b010,
    OP_XOR = 3'b011,
    OP_MUL = 3'b100,
    OP_SUB = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_WAIT_LOW
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2:0]         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]      result_q, result_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic [RW-1:0]      alu_res;
  logic               alu_err;

  // Datapath works only on the captured operands, so bus changes after capture are ignored.
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (op_q)
      OP_ADD:  alu_res = RW'(a_q) + RW'(b_q);
      OP_AND:  alu_res = RW'(a_q & b_q);
      OP_XOR:  alu_res = RW'(a_q ^ b_q);
      OP_MUL:  alu_res = RW'(a_q) * RW'(b_q);
      OP_SUB:  alu_res = RW'(a_q) - RW'(b_q);
      default: alu_err = 1'b1;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;
    done_d   = 1'b0;
    busy_d   = busy_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start && (bus.op != OP_NOP)) begin
          a_d     = bus.A;
          b_d     = bus.B;
          op_d    = bus.op;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ((bus.op == OP_MUL) && (MUL_LAT > 1)) ? S_MUL : S_EXEC;
        end
      end
      S_EXEC: begin
        result_d = alu_res;
        err_d    = alu_err;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_WAIT_LOW;
      end
      S_MUL: begin
        if (cnt_q == CNT_LAST) begin
          result_d = alu_res;
          err_d    = alu_err;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_WAIT_LOW;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_LOW: begin
        if (!bus.start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the operand/opcode capture registers are reset too, so nothing downstream
  // ever sees X after reset even though they are only consumed after a capture.
  // NOTE: state is updated with non-blocking assignments so all registers sample
  // the same pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.err    = err_q;
  assign bus.busy   = busy_q;
endmodule
